// File: rtl/psum_pack_ctrl.sv
// Round-robin collects DW-bit psums from N_PE PEs into 4-slot words; a word is visible one edge after its last slot fills.
// A blocked output register parks a full word in HOLD (grants stop); flush closes a partial word zero-padded.
module psum_pack_ctrl #(
  parameter int N_PE  = 4,
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_PE-1:0]      req_i,
  input  logic [N_PE*DW-1:0]   din_i,
  output logic [N_PE-1:0]      gnt_o,
  input  logic                 flush_i,
  output logic [4*DW-1:0]      pkd_data_o,
  output logic                 pkd_valid_o,
  input  logic                 pkd_ready_i,
  output logic                 busy_o,
  output logic [CNT_W-1:0]     word_cnt_o
);

  localparam int PW = $clog2(N_PE);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       pos_q, pos_d;
  logic [PW-1:0]    rr_q, rr_d;
  logic [DW-1:0]    slot_q [4];
  logic [DW-1:0]    slot_d [4];
  logic             flush_pend_q, flush_pend_d;
  logic [4*DW-1:0]  data_q, data_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             out_free;
  logic             flush_act;
  logic             gnt_any;
  logic             grant_ok;
  logic [PW-1:0]    gnt_idx;
  logic [PW:0]      cand;
  logic [DW-1:0]    gnt_dat;
  logic [4*DW-1:0]  flush_word;

  // First requester at or after rr_q, wrapping modulo N_PE.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < N_PE; k++) begin
      cand = {1'b0, rr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(N_PE)) cand = cand - (PW+1)'(N_PE);
      if (!gnt_any && req_i[cand[PW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[PW-1:0];
      end
    end
  end

  assign out_free   = !valid_q || pkd_ready_i;
  assign flush_act  = flush_i || flush_pend_q;
  assign grant_ok   = (state_q == FILL) && !flush_act && gnt_any;
  assign gnt_dat    = din_i[gnt_idx*DW +: DW];
  assign flush_word = {slot_q[0] & {DW{pos_q > 2'd0}},
                       slot_q[1] & {DW{pos_q > 2'd1}},
                       slot_q[2] & {DW{pos_q > 2'd2}},
                       {DW{1'b0}}};

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= FILL;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (grant_ok && pos_q == 2'd3 && !out_free) state_d = HOLD;
      HOLD:    if (out_free) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    pos_d        = pos_q;
    rr_d         = rr_q;
    slot_d       = slot_q;
    flush_pend_d = flush_pend_q;
    data_d       = data_q;
    valid_d      = valid_q && !pkd_ready_i;
    cnt_d        = cnt_q + CNT_W'(valid_q && pkd_ready_i);
    if (state_q == HOLD) begin
      // A flush seen here belongs to whatever word follows the held one.
      if (flush_i) flush_pend_d = 1'b1;
      if (out_free) begin
        data_d  = {slot_q[0], slot_q[1], slot_q[2], slot_q[3]};
        valid_d = 1'b1;
        pos_d   = 2'd0;
      end
    end else if (flush_act) begin
      if (pos_q == 2'd0) begin
        flush_pend_d = 1'b0;
      end else if (out_free) begin
        data_d       = flush_word;
        valid_d      = 1'b1;
        pos_d        = 2'd0;
        flush_pend_d = 1'b0;
      end else begin
        flush_pend_d = 1'b1;
      end
    end else if (grant_ok) begin
      slot_d[pos_q] = gnt_dat;
      rr_d = (gnt_idx == PW'(N_PE-1)) ? '0 : gnt_idx + PW'(1);
      if (pos_q != 2'd3) begin
        pos_d = pos_q + 2'd1;
      end else if (out_free) begin
        data_d  = {slot_q[0], slot_q[1], slot_q[2], gnt_dat};
        valid_d = 1'b1;
        pos_d   = 2'd0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos_q        <= 2'd0;
      rr_q         <= '0;
      slot_q       <= '{default: '0};
      flush_pend_q <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      pos_q        <= pos_d;
      rr_q         <= rr_d;
      slot_q       <= slot_d;
      flush_pend_q <= flush_pend_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign gnt_o       = grant_ok ? (N_PE'(1) << gnt_idx) : '0;
  assign pkd_data_o  = data_q;
  assign pkd_valid_o = valid_q;
  assign word_cnt_o  = cnt_q;
  assign busy_o      = (pos_q != 2'd0) || (state_q == HOLD) || flush_pend_q || valid_q;

endmodule

// File: tb/tb_psum_pack_ctrl.sv
// Bench for psum_pack_ctrl: directed scenarios with literal expectations plus a randomized run,
// all checked against a queue-based model of the word packer.
module tb_psum_pack_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req;
  logic [N*16-1:0] din;
  logic           flush;
  logic           ready;
  logic [N-1:0]   gnt, gnt2;
  logic [63:0]    pdata, pdata2;
  logic           pvalid, pvalid2, busy, busy2;
  logic [15:0]    cnt;
  logic [1:0]     cnt2;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  psum_pack_ctrl #(.N_PE(N), .DW(16), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .din_i(din), .gnt_o(gnt),
    .flush_i(flush), .pkd_data_o(pdata), .pkd_valid_o(pvalid),
    .pkd_ready_i(ready), .busy_o(busy), .word_cnt_o(cnt)
  );

  psum_pack_ctrl #(.N_PE(N), .DW(16), .CNT_W(2)) dut_w2 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .din_i(din), .gnt_o(gnt2),
    .flush_i(flush), .pkd_data_o(pdata2), .pkd_valid_o(pvalid2),
    .pkd_ready_i(ready), .busy_o(busy2), .word_cnt_o(cnt2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the psums of the word being built sit in a queue; four queued means the word is parked.
  logic [15:0] m_q[$];
  int          m_rr  = 0;
  bit          m_fp  = 1'b0;
  bit          m_ov  = 1'b0;
  logic [63:0] m_od  = '0;
  int          m_cnt = 0;

  always @(negedge clk) begin : model
    logic [N-1:0] eg;
    int           gi;
    bit           free, ld;
    logic [63:0]  w;
    eg = '0;
    gi = -1;
    if (m_q.size() < 4 && !flush && !m_fp)
      for (int k = 0; k < N; k++)
        if (gi < 0 && req[(m_rr + k) % N]) gi = (m_rr + k) % N;
    if (gi >= 0) eg[gi] = 1'b1;
    if (chk_en) begin
      chk("gnt", 64'(gnt), 64'(eg));
      chk("pkd_valid", 64'(pvalid), 64'(m_ov));
      chk("pkd_data", pdata, m_od);
      chk("word_cnt", 64'(cnt), 64'(m_cnt % 65536));
      chk("word_cnt_w2", 64'(cnt2), 64'(m_cnt % 4));
      chk("busy", 64'(busy), 64'(m_q.size() != 0 || m_fp || m_ov));
    end
    if (rst) begin
      m_q.delete();
      m_rr = 0; m_fp = 1'b0; m_ov = 1'b0; m_od = '0; m_cnt = 0;
    end else begin
      free = !m_ov || ready;
      ld = 1'b0;
      w = '0;
      if (m_q.size() == 4) begin
        if (flush) m_fp = 1'b1;
        if (free) ld = 1'b1;
      end else if (flush || m_fp) begin
        if (m_q.size() == 0) m_fp = 1'b0;
        else if (free) begin ld = 1'b1; m_fp = 1'b0; end
        else m_fp = 1'b1;
      end else if (gi >= 0) begin
        m_q.push_back(din[gi*16 +: 16]);
        m_rr = (gi + 1) % N;
        if (m_q.size() == 4 && free) ld = 1'b1;
      end
      if (ld) for (int j = 0; j < m_q.size(); j++) w[(3-j)*16 +: 16] = m_q[j];
      if (m_ov && ready) m_cnt++;
      if (ld) begin m_od = w; m_ov = 1'b1; m_q.delete(); end
      else if (ready) m_ov = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [15:0] v);
    for (int i = 0; i < N; i++) din[i*16 +: 16] = v;
  endtask

  initial begin
    rst = 1'b1; req = '0; din = '0; flush = 1'b0; ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // reset state
    @(negedge clk);
    chk("t1_gnt", 64'(gnt), 64'd0);
    chk("t1_valid", 64'(pvalid), 64'd0);
    chk("t1_data", pdata, 64'd0);
    chk("t1_cnt", 64'(cnt), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);

    // round-robin with all PEs requesting
    step();
    req = 4'hF;
    for (int i = 0; i < N; i++) din[i*16 +: 16] = 16'h00A0 + 16'(i);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t3_gnt_order", 64'(gnt), 64'(1) << (k % 4));
      if (k == 4) chk("t3_word1", pdata, 64'h00A0_00A1_00A2_00A3);
      step();
    end
    req = '0;
    @(negedge clk);
    chk("t3_word2_valid", 64'(pvalid), 64'd1);
    chk("t3_word2", pdata, 64'h00A0_00A1_00A2_00A3);
    step();

    // single PE, four psums
    req = 4'b0001;
    for (int v = 1; v <= 4; v++) begin
      din[15:0] = 16'(v);
      @(negedge clk);
      chk("t2_gnt", 64'(gnt), 64'd1);
      step();
    end
    req = '0;
    @(negedge clk);
    chk("t2_valid", 64'(pvalid), 64'd1);
    chk("t2_word", pdata, 64'h0001_0002_0003_0004);
    step();
    @(negedge clk);
    chk("t2_cnt", 64'(cnt), 64'd3);
    chk("t2_valid_drop", 64'(pvalid), 64'd0);

    // backpressure: eight psums offered while downstream stalls
    step();
    ready = 1'b0;
    req = 4'hF;
    for (int c = 0; c < 8; c++) begin
      set_all(16'h0B00 + 16'(c));
      @(negedge clk);
      chk("t4_accept", 64'(gnt != '0), 64'd1);
      step();
    end
    @(negedge clk);
    chk("t4_hold_gnt", 64'(gnt), 64'd0);
    chk("t4_held_word", pdata, 64'h0B00_0B01_0B02_0B03);
    step();
    @(negedge clk);
    chk("t4_hold_gnt2", 64'(gnt), 64'd0);
    chk("t4_held_word2", pdata, 64'h0B00_0B01_0B02_0B03);
    step();
    ready = 1'b1;
    req = '0;
    step();
    @(negedge clk);
    chk("t4_word2", pdata, 64'h0B04_0B05_0B06_0B07);
    chk("t4_word2_valid", 64'(pvalid), 64'd1);
    step();
    @(negedge clk);
    chk("t4_cnt", 64'(cnt), 64'd5);

    // flush of a two-psum partial word, then a flush with nothing pending
    step();
    req = 4'b0001;
    din[15:0] = 16'h0011;
    step();
    din[15:0] = 16'h0022;
    step();
    req = '0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("t5_valid", 64'(pvalid), 64'd1);
    chk("t5_word", pdata, 64'h0011_0022_0000_0000);
    step();
    @(negedge clk);
    chk("t5_cnt", 64'(cnt), 64'd6);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("t5_empty_flush_valid", 64'(pvalid), 64'd0);
    chk("t5_empty_flush_busy", 64'(busy), 64'd0);

    // reset after three psums
    step();
    req = 4'b0001;
    din[15:0] = 16'h0077;
    repeat (3) step();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid", 64'(pvalid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_data", pdata, 64'd0);
    chk("t6_cnt", 64'(cnt), 64'd0);

    // five words delivered: 2-bit counter wraps to 1
    step();
    req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      din[15:0] = 16'(c);
      step();
    end
    req = '0;
    step();
    @(negedge clk);
    chk("t6_wrap_cnt2", 64'(cnt2), 64'd1);
    chk("t6_cnt5", 64'(cnt), 64'd5);

    // randomized traffic
    repeat (3000) begin
      step();
      req = N'($urandom);
      for (int i = 0; i < N; i++) din[i*16 +: 16] = 16'($urandom);
      flush = ($urandom_range(0, 9) == 0);
      ready = ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 399) == 0);
    end
    step();
    req = '0; flush = 1'b0; rst = 1'b0; ready = 1'b1;
    repeat (10) step();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
